// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources,
// issuing one start pulse per frame and tracking tx_busy until the frame completes.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no frame in flight; arbitrate over req each cycle
// S_ISSUE     | tx_data_valid and req_ack pulse for the latched requester
// S_WAIT_BUSY | waiting for tx_busy to rise, bounded by BUSY_TIMEOUT
// S_WAIT_DONE | frame in progress; wait for tx_busy to fall
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_parity_en,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic                          tx_busy,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_parity_enable,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(BUSY_TIMEOUT);
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [IDW-1:0]        last, last_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic                  cnt_tc;
    logic                  pick_valid;
    logic [IDW-1:0]        pick_idx;
    logic [IDW:0]          sum;
    logic [IDW:0]          wrapped;
    logic                  valid_d, timeout_d, active_d, par_d;
    logic [NUM_REQ-1:0]    ack_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic [IDW-1:0]        grant_d;

    // Timer counts down from BUSY_TIMEOUT-1; terminal count is zero.
    assign cnt_tc = (cnt == '0);

    // Search starts just past the last winner and wraps, first hit wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        wrapped    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum     = {1'b0, last} + (IDW+1)'(k);
            wrapped = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
            if (!pick_valid && req[wrapped[IDW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = wrapped[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            last             <= LAST_RST;
            cnt              <= '0;
            req_ack          <= '0;
            tx_data_valid    <= 1'b0;
            tx_data          <= '0;
            tx_parity_enable <= 1'b0;
            grant_id         <= '0;
            active           <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            state            <= next_state;
            last             <= last_d;
            cnt              <= cnt_d;
            req_ack          <= ack_d;
            tx_data_valid    <= valid_d;
            tx_data          <= data_d;
            tx_parity_enable <= par_d;
            grant_id         <= grant_d;
            active           <= active_d;
            timeout_err      <= timeout_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (pick_valid) next_state = S_ISSUE;
            S_ISSUE:     next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (tx_busy)     next_state = S_WAIT_DONE;
                else if (cnt_tc) next_state = S_IDLE;
            end
            S_WAIT_DONE: if (!tx_busy) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the pulses land in ISSUE / first IDLE cycle.
    always_comb begin
        valid_d   = (state == S_IDLE) && pick_valid;
        ack_d     = '0;
        data_d    = tx_data;
        par_d     = tx_parity_enable;
        grant_d   = grant_id;
        last_d    = last;
        cnt_d     = cnt;
        timeout_d = (state == S_WAIT_BUSY) && !tx_busy && cnt_tc;
        active_d  = (next_state != S_IDLE);
        if (valid_d) begin
            ack_d[pick_idx] = 1'b1;
            data_d          = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            par_d           = req_parity_en[pick_idx];
            grant_d         = pick_idx;
            last_d          = pick_idx;
        end
        if (state == S_ISSUE)
            cnt_d = CNT_LOAD;
        else if ((state == S_WAIT_BUSY) && !tx_busy && !cnt_tc)
            cnt_d = cnt - CW'(1);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed frame table, two hand-written corner sequences,
// then random requesters and a random transmitter checked against a transaction model.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0] req_parity_en = '0;
    logic [NR-1:0] req_ack;
    logic          tx_busy = 1'b0;
    logic          tx_data_valid;
    logic [DW-1:0] tx_data;
    logic          tx_parity_enable;
    logic [1:0]    grant_id;
    logic          active;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .req_parity_en(req_parity_en), .req_ack(req_ack), .tx_busy(tx_busy),
        .tx_data_valid(tx_data_valid), .tx_data(tx_data),
        .tx_parity_enable(tx_parity_enable), .grant_id(grant_id),
        .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] data;
        logic [3:0]  par;
        int          d;
        int          len;
        int          eg;
        logic [7:0]  ed;
        logic        ep;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first set bit after 'last', wrapping.
    function automatic int rr(input int last, input logic [3:0] r);
        for (int k = 1; k <= NR; k++)
            if (r[2'((last + k) % NR)]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, tx_data_valid, 0);
        chk({tag, "_ack"}, req_ack, 0);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_par"}, tx_parity_enable, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_timeout"}, timeout_err, 0);
    endtask

    // Apply a request while idle; the start pulse must follow on the very next cycle.
    task automatic issue_check(input logic [3:0] r, input int eg, input logic [7:0] ed, input logic ep);
        req = r;
        step();
        chk("issue_valid", tx_data_valid, 1);
        chk("issue_ack", req_ack, 32'(1) << eg);
        chk("issue_grant", grant_id, eg);
        chk("issue_data", tx_data, ed);
        chk("issue_par", tx_parity_enable, ep);
        chk("issue_active", active, 1);
        chk("issue_timeout", timeout_err, 0);
        req = '0;
        tx_busy = 1'b0;
    endtask

    // Transmitter raises busy d cycles after the start pulse for len cycles (d=0: never).
    task automatic frame_tail(input int d, input int len, input int eg, input logic [7:0] ed, input logic ep);
        int fin;
        fin = (d == 0) ? BT + 1 : d + len + 1;
        for (int t = 1; t <= fin; t++) begin
            step();
            chk("tail_valid_low", tx_data_valid, 0);
            chk("tail_ack_low", req_ack, 0);
            chk("tail_active", active, 32'(t < fin));
            chk("tail_timeout", timeout_err, 32'((d == 0) && (t == fin)));
            chk("tail_data_hold", tx_data, ed);
            chk("tail_par_hold", tx_parity_enable, ep);
            chk("tail_grant_hold", grant_id, eg);
            tx_busy = (d != 0) && (t >= d) && (t < d + len);
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        int nxt_idle, vcyc, rd, rl, lastg, held_g, eg;
        logic [3:0]  req_prev, par_prev;
        logic [31:0] data_prev;
        logic [7:0]  held_d;
        logic        held_p;

        tbl[0]  = '{4'b1111, 32'h13121110, 4'b1010, 1, 3, 0, 8'h10, 1'b0};
        tbl[1]  = '{4'b1110, 32'h13121110, 4'b1010, 1, 3, 1, 8'h11, 1'b1};
        tbl[2]  = '{4'b1100, 32'h13121110, 4'b1010, 2, 2, 2, 8'h12, 1'b0};
        tbl[3]  = '{4'b1000, 32'h13121110, 4'b1010, 1, 1, 3, 8'h13, 1'b1};
        tbl[4]  = '{4'b0001, 32'h000000A5, 4'b0001, 1, 11, 0, 8'hA5, 1'b1};
        tbl[5]  = '{4'b0100, 32'h44332211, 4'b0110, 4, 2, 2, 8'h33, 1'b1};
        tbl[6]  = '{4'b0101, 32'h44332211, 4'b0110, 3, 1, 0, 8'h11, 1'b0};
        tbl[7]  = '{4'b0101, 32'h44332211, 4'b0110, 1, 2, 2, 8'h33, 1'b1};
        tbl[8]  = '{4'b1000, 32'h44332211, 4'b0110, 0, 0, 3, 8'h44, 1'b0};
        tbl[9]  = '{4'b0010, 32'h44332211, 4'b0110, 1, 4, 1, 8'h22, 1'b1};
        tbl[10] = '{4'b1010, 32'h44332211, 4'b0110, 2, 1, 3, 8'h44, 1'b0};
        tbl[11] = '{4'b1011, 32'h44332211, 4'b0110, 1, 1, 0, 8'h11, 1'b0};

        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            req_data      = tbl[i].data;
            req_parity_en = tbl[i].par;
            issue_check(tbl[i].r, tbl[i].eg, tbl[i].ed, tbl[i].ep);
            frame_tail(tbl[i].d, tbl[i].len, tbl[i].eg, tbl[i].ed, tbl[i].ep);
        end

        // Byte changes on the ISSUE cycle must not disturb the latched value.
        req_data      = 32'h0000003C;
        req_parity_en = 4'b0000;
        issue_check(4'b0001, 0, 8'h3C, 1'b0);
        req_data = 32'h000000FF;
        frame_tail(1, 3, 0, 8'h3C, 1'b0);

        // Reset asserted during WAIT_DONE clears everything without a clock edge.
        req_data      = 32'h44332211;
        req_parity_en = 4'b0110;
        issue_check(4'b0100, 2, 8'h33, 1'b1);
        step();
        tx_busy = 1'b1;
        step();
        step();
        chk("pre_reset_active", active, 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        issue_check(4'b0010, 1, 8'h22, 1'b1);
        frame_tail(1, 2, 1, 8'h22, 1'b1);

        // Random traffic against a transaction-level model.
        nxt_idle = -1; vcyc = -100; rd = 1; rl = 1; lastg = 1;
        held_g = 1; held_d = 8'h22; held_p = 1'b1;
        req_prev = '0; par_prev = req_parity_en; data_prev = req_data;
        for (int c = 0; c < 400; c++) begin
            step();
            if ((c - 1 >= nxt_idle) && (req_prev != 0)) begin
                eg = rr(lastg, req_prev);
                held_g = eg;
                held_d = data_prev[eg*DW +: DW];
                held_p = par_prev[2'(eg)];
                chk("rnd_valid", tx_data_valid, 1);
                chk("rnd_ack", req_ack, 32'(1) << eg);
                lastg = eg;
                vcyc  = c;
                rd    = $urandom_range(0, BT);
                rl    = $urandom_range(1, 6);
                nxt_idle = (rd == 0) ? c + BT + 1 : c + rd + rl + 1;
                req[2'(eg)] = 1'b0;
            end else begin
                chk("rnd_valid_low", tx_data_valid, 0);
                chk("rnd_ack_low", req_ack, 0);
            end
            chk("rnd_active", active, 32'(c < nxt_idle));
            chk("rnd_timeout", timeout_err, 32'((rd == 0) && (c == vcyc + BT + 1)));
            chk("rnd_grant", grant_id, held_g);
            chk("rnd_data", tx_data, held_d);
            chk("rnd_par", tx_parity_enable, held_p);
            tx_busy = (rd != 0) && (c >= vcyc + rd) && (c < vcyc + rd + rl);
            for (int i = 0; i < NR; i++) begin
                if (!req[2'(i)] && ($urandom_range(0, 3) == 0)) begin
                    req[2'(i)] = 1'b1;
                    req_data[i*DW +: DW] = 8'($urandom);
                    req_parity_en[2'(i)] = 1'($urandom);
                end
            end
            req_prev  = req;
            data_prev = req_data;
            par_prev  = req_parity_en;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
